fp_norm_round: RTL
==================

// Module: fp_norm_round
// PURPOSE
//  Back end of the FP adder: takes the raw sum mantissa (carry+hidden+frac+GRS), renormalises and rounds it.
//  Normalisation is iterative: one left shift per cycle, or a single right shift on carry-out.
//  Rounding is round-to-nearest-even. Output is the packed sign/exp/frac, plus zero and overflow flags.
//  Sits downstream of the operand swap/align and mantissa add stages. Valid/ready on both sides.
// PARAMETERS
//  EXP_W   4  exponent width; bias 2^(EXP_W-1)-1; exp 0 = zero, exp all-ones = inf
//  MANT_W  4  mantissa width incl. hidden bit; out_frac = MANT_W-1 bits
//  GRS_W   3  guard/round/sticky bits below mantissa LSB (fixed order G,R,S)
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  asynchronous reset, active-high
//  in_valid   in   1                  input sum valid
//  in_ready   out  1                  block idle, can accept
//  in_sign    in   1                  result sign from adder
//  in_exp     in   EXP_W              exponent of larger operand
//  in_mant    in   MANT_W+GRS_W+1     {carry, hidden, frac, G, R, S}; default 8b: [7]C [6]H [5:3]F [2]G [1]R [0]S
//  out_valid  out  1                  result valid, held until out_ready
//  out_ready  in   1                  downstream accepts
//  out_sign   out  1                  result sign (preserved on zero/ovf)
//  out_exp    out  EXP_W              result exponent
//  out_frac   out  MANT_W-1           result fraction, hidden bit dropped
//  out_zero   out  1                  result flushed to zero
//  out_ovf    out  1                  result saturated to inf
// BEHAVIOUR
//  Reset: state IDLE; all out_* regs 0; out_valid 0; in_ready=(state==IDLE), so 1 during/after reset. Reset mid-op drops the op silently.
//  FSM IDLE->NORM->ROUND->OUT->IDLE. Accept = in_valid&in_ready in IDLE; latch sign/exp/mant.
//  NORM (one decision per cycle, priority order):
//   a) mant==0 or exp==0 -> zero result, go OUT.
//   b) carry set -> shift right 1, exp+1, shifted-out bit ORed into S; go ROUND.
//   c) hidden set -> go ROUND.
//   d) else if exp==1 -> underflow, zero result, go OUT.
//   e) else shift whole vector left 1 (S<-0), exp-1; stay in NORM.
//  ROUND: inc = G & (R|S|LSB). mant+inc carries out -> mant=100..0, exp+1.
//   Final exp == all-ones (from b or rounding) -> out_exp=all-ones, out_frac=0, out_ovf=1. Go OUT.
//  Zero result: out_exp=0, out_frac=0, out_zero=1.
//  OUT: out_valid=1; outputs stable while !out_ready; on out_ready -> IDLE, out_valid=0 next cycle.
//  in_ready is low in NORM/ROUND/OUT; no back-to-back overlap. Min throughput: 1 op per 4 cycles.
//  Latency (accept edge to out_valid high), n = left shifts: zero/exp0 = 2; carry or normalised = 3; left shift = n+3.
//  Underflow case: n shifts, then 1 extra NORM cycle -> n+2.
//  out_zero and out_ovf are never both set; out_valid never rises without a prior accept.
// STRUCTURE
//  Package fp_add_pkg: EXP_W/MANT_W/GRS_W defaults, EXP_MAX localparam, norm_state_t enum {IDLE,NORM,ROUND,OUT}.
//  Package is shared with the align/add stages.
//  One sub-module, fp_round_rne: combinational; {mant,G,R,S} -> rounded mant + carry-out.
// TESTING
//  1. exp=5, mant=1_1010_000 -> exp 6, frac 101, zero/ovf 0; out_valid 3 edges after accept.
//  2. exp=6, mant=0_0011_010 -> 2 left shifts, exp 4, frac 101; out_valid 5 edges after accept.
//  3. RNE: exp=7, mant=0_1011_100 -> frac 100; 0_1010_100 -> frac 010 (tie to even); 0_1010_101 -> frac 011.
//  4. Round carry/ovf: exp=14, mant=0_1111_110 -> out_exp 15, frac 000, out_ovf 1.
//     Carry at exp=14: mant=1_1000_000 -> exp 15, out_ovf 1.
//  5. Underflow/zero: exp=2, mant=0_0001_000 -> out_zero 1, out_exp 0, sign kept.
//     mant=0 -> out_zero after 2 edges.
//  6. Backpressure: out_ready=0 for 4 cycles -> outputs stable, in_ready 0.
//     rst pulse during NORM -> outputs 0, in_ready 1; next op completes correctly.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared definitions for the floating-point adder pipeline.
// The align, add and normalise/round stages all use these widths, so
// changing a format width here changes it for the whole adder.
package fp_add_pkg;

  // Exponent width; the bias is 2^(EXP_W-1)-1.
  // Exponent 0 encodes zero and all-ones encodes infinity.
  localparam int EXP_W  = 4;

  // Mantissa width including the hidden bit.
  localparam int MANT_W = 4;

  // Guard, round and sticky bits kept below the mantissa LSB.
  localparam int GRS_W  = 3;

  // Width of the raw sum vector: {carry, hidden, frac, G, R, S}.
  localparam int VEC_W  = MANT_W + GRS_W + 1;

  // All-ones exponent, used as the infinity/saturation encoding.
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  // Back-end sequencing: accept, normalise, round, then present the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } norm_state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a normalised mantissa.
// When the increment ripples out of the top bit, the mantissa becomes
// 100..0 and carry_o tells the caller to bump the exponent.
module fp_round_rne #(
  parameter int MANT_W = 4
) (
  input  logic [MANT_W-1:0] mant_i,
  input  logic              guard_i,
  input  logic              round_i,
  input  logic              sticky_i,
  output logic [MANT_W-1:0] mant_o,
  output logic              carry_o
);

  logic              incr;
  logic [MANT_W:0]   sum;

  // Round up above the halfway point; on an exact tie, round up only when the LSB is odd.
  always_comb begin
    incr    = guard_i & (round_i | sticky_i | mant_i[0]);
    sum     = {1'b0, mant_i} + {{MANT_W{1'b0}}, incr};
    carry_o = sum[MANT_W];
    mant_o  = sum[MANT_W-1:0];
    if (sum[MANT_W]) begin
      mant_o = {1'b1, {(MANT_W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Back end of the FP adder.
// This stage takes the raw sum mantissa, renormalises it, and rounds it to
// nearest-even. It then presents the packed sign/exp/frac together with the
// zero and overflow flags. Normalisation shifts left one bit per cycle, or
// shifts right once when the add carried out. One operation is in flight
// at a time.
module fp_norm_round
  import fp_add_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [VEC_W-1:0]  in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-2:0] out_frac,
  output logic              out_zero,
  output logic              out_ovf
);

  // One extra exponent bit so that carry and rounding increments on an
  // already-large exponent cannot wrap back to a small value.
  localparam logic [EXP_W:0] EXP_ONE     = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_MAX_EXT = {1'b0, EXP_MAX};

  norm_state_t       state_q;
  logic              sign_q;
  logic [EXP_W:0]    exp_q;
  logic [VEC_W-1:0]  mant_q;

  logic              out_valid_q;
  logic              out_sign_q;
  logic [EXP_W-1:0]  out_exp_q;
  logic [MANT_W-2:0] out_frac_q;
  logic              out_zero_q;
  logic              out_ovf_q;

  // Named views of the working vector fields.
  logic              carry_bit;
  logic              hidden_bit;
  logic [MANT_W-1:0] body_mant;
  logic              guard_bit;
  logic              round_bit;
  logic              sticky_bit;
  logic              is_zero;

  logic [VEC_W-1:0]  shr_mant_d;
  logic [VEC_W-1:0]  shl_mant_d;
  logic [MANT_W-1:0] rnd_mant_d;
  logic              rnd_carry_d;
  logic [EXP_W:0]    rnd_exp_d;
  logic              rnd_ovf_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_frac  = out_frac_q;
  assign out_zero  = out_zero_q;
  assign out_ovf   = out_ovf_q;

  // Split the working vector into carry/hidden/mantissa/GRS fields and precompute both shift candidates.
  always_comb begin
    carry_bit  = mant_q[VEC_W-1];
    hidden_bit = mant_q[VEC_W-2];
    body_mant  = mant_q[VEC_W-2:GRS_W];
    guard_bit  = mant_q[GRS_W-1];
    round_bit  = mant_q[GRS_W-2];
    sticky_bit = |mant_q[GRS_W-3:0];
    is_zero    = (mant_q == '0) || (exp_q == '0);
    // A right shift must not lose the bit falling off the bottom, so it is folded into sticky.
    shr_mant_d = {1'b0, mant_q[VEC_W-1:2], mant_q[1] | mant_q[0]};
    shl_mant_d = {mant_q[VEC_W-2:0], 1'b0};
  end

  fp_round_rne #(
    .MANT_W (MANT_W)
  ) u_round (
    .mant_i   (body_mant),
    .guard_i  (guard_bit),
    .round_i  (round_bit),
    .sticky_i (sticky_bit),
    .mant_o   (rnd_mant_d),
    .carry_o  (rnd_carry_d)
  );

  // Final exponent after rounding; anything at or past all-ones saturates to infinity.
  always_comb begin
    rnd_exp_d = exp_q + {{EXP_W{1'b0}}, rnd_carry_d};
    rnd_ovf_d = (rnd_exp_d >= EXP_MAX_EXT);
  end

  // Sequencer: latch the operand, normalise a step per cycle, round, then hold the result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_frac_q  <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            exp_q   <= {1'b0, in_exp};
            mant_q  <= in_mant;
            state_q <= NORM;
          end
        end

        NORM: begin
          if (is_zero) begin
            out_sign_q <= sign_q;
            out_exp_q  <= '0;
            out_frac_q <= '0;
            out_zero_q <= 1'b1;
            out_ovf_q  <= 1'b0;
            state_q    <= OUT;
          end else if (carry_bit) begin
            mant_q  <= shr_mant_d;
            exp_q   <= exp_q + EXP_ONE;
            state_q <= ROUND;
          end else if (hidden_bit) begin
            state_q <= ROUND;
          end else if (exp_q == EXP_ONE) begin
            // Shifting further would push the exponent to the zero encoding.
            out_sign_q <= sign_q;
            out_exp_q  <= '0;
            out_frac_q <= '0;
            out_zero_q <= 1'b1;
            out_ovf_q  <= 1'b0;
            state_q    <= OUT;
          end else begin
            mant_q <= shl_mant_d;
            exp_q  <= exp_q - EXP_ONE;
          end
        end

        ROUND: begin
          out_sign_q <= sign_q;
          out_zero_q <= 1'b0;
          if (rnd_ovf_d) begin
            out_exp_q  <= EXP_MAX;
            out_frac_q <= '0;
            out_ovf_q  <= 1'b1;
          end else begin
            out_exp_q  <= rnd_exp_d[EXP_W-1:0];
            out_frac_q <= rnd_mant_d[MANT_W-2:0];
            out_ovf_q  <= 1'b0;
          end
          state_q <= OUT;
        end

        OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A result is either zero or infinity, never both.
  assert property (@(posedge clk) disable iff (rst) !(out_zero && out_ovf));

  // A presented result stays put until the consumer takes it.
  assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable({out_sign, out_exp, out_frac, out_zero, out_ovf})));

endmodule
